// File: rtl/jacobi_matrix_io_controller.sv
// Jacobi matrix I/O controller.
// Streams an N x N matrix from a microcontroller into a dual-port RAM, kicks
// the Jacobi engine, waits for it, then streams the matrix back out.
// Optional build macro: JACOBI_SYM_LOAD_EN -- load only the upper triangle and
// mirror every off-diagonal element through RAM port B.
//
// Handshake semantics (both streams): a beat transfers on a rising clk edge
// where valid && ready are both 1; a source holding valid keeps its data
// stable until the transfer; ready may depend on state but never on valid.
module jacobi_matrix_io_controller #(
  parameter int DATA_W = 16,
  parameter int N      = 4,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_dat_i,
  input  logic              in_vld_i,
  output logic              in_rdy_o,
  output logic [DATA_W-1:0] out_dat_o,
  output logic              out_vld_o,
  input  logic              out_rdy_i,
  output logic              calc_start_o,
  input  logic              calc_done_i,
  output logic              ram_en_a_o,
  output logic              ram_we_a_o,
  output logic [ADDR_W-1:0] ram_addr_a_o,
  output logic [DATA_W-1:0] ram_din_a_o,
  input  logic [DATA_W-1:0] ram_dout_a_i,
  output logic              ram_en_b_o,
  output logic              ram_we_b_o,
  output logic [ADDR_W-1:0] ram_addr_b_o,
  output logic [DATA_W-1:0] ram_din_b_o,
  output logic [2:0]        dbg_state_o
);

  localparam int NN = N * N;
`ifdef JACOBI_SYM_LOAD_EN
  localparam int NLOAD = N * (N + 1) / 2;
`else
  localparam int NLOAD = NN;
`endif
  localparam int CNT_W = $clog2(NN + 1);
  localparam int IDX_W = $clog2(N);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    FLUSH  = 3'd2,
    CALC   = 3'd3,
    UNLOAD = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Load side
  logic [CNT_W-1:0]  r_in_cnt;
  logic [IDX_W-1:0]  r_row;
  logic [IDX_W-1:0]  r_col;
  logic              r_wr_pend;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;
`ifdef JACOBI_SYM_LOAD_EN
  logic              r_wrb_pend;
  logic [ADDR_W-1:0] r_wrb_addr;
`endif

  // Calc side
  logic r_calc_first;

  // Unload side: read issue counter, one read in flight, 4-entry skid FIFO
  logic [CNT_W-1:0]  r_rd_cnt;
  logic [CNT_W-1:0]  r_out_cnt;
  logic              r_rd_pend;
  logic [DATA_W-1:0] r_mem [0:3];
  logic [1:0]        r_wptr;
  logic [1:0]        r_rptr;
  logic [2:0]        r_fifo_cnt;

  logic w_accept;
  logic w_last_in;
  logic w_pop;
  logic w_last_out;
  logic w_rd_issue;

  function automatic logic [ADDR_W-1:0] elem_addr(input logic [IDX_W-1:0] row,
                                                  input logic [IDX_W-1:0] col);
    logic [31:0] tmp;
    tmp = 32'(row) * 32'(N) + 32'(col);
    return tmp[ADDR_W-1:0];
  endfunction

  assign in_rdy_o   = !rst && (r_state == IDLE || r_state == LOAD);
  assign w_accept   = in_vld_i && in_rdy_o;
  assign w_last_in  = (r_in_cnt == CNT_W'(NLOAD - 1));
  assign out_vld_o  = !rst && (r_fifo_cnt != 3'd0);
  assign out_dat_o  = r_mem[r_rptr];
  assign w_pop      = out_vld_o && out_rdy_i;
  assign w_last_out = (r_out_cnt == CNT_W'(NN - 1));
  // A read is only issued when a FIFO slot is guaranteed for its data.
  assign w_rd_issue = !rst && (r_state == UNLOAD) && (r_rd_cnt < CNT_W'(NN)) &&
                      ((r_fifo_cnt + {2'b00, r_rd_pend}) < 3'd4);

  assign calc_start_o = !rst && (r_state == CALC) && r_calc_first;
  assign dbg_state_o  = r_state;

  // Port A: pending load write has priority (never overlaps with UNLOAD reads)
  assign ram_en_a_o   = !rst && (r_wr_pend || w_rd_issue);
  assign ram_we_a_o   = !rst && r_wr_pend;
  assign ram_addr_a_o = r_wr_pend  ? r_wr_addr :
                        w_rd_issue ? ADDR_W'(r_rd_cnt) : '0;
  assign ram_din_a_o  = r_wr_pend  ? r_wr_data : '0;

`ifdef JACOBI_SYM_LOAD_EN
  assign ram_en_b_o   = !rst && r_wrb_pend;
  assign ram_we_b_o   = !rst && r_wrb_pend;
  assign ram_addr_b_o = r_wrb_pend ? r_wrb_addr : '0;
  assign ram_din_b_o  = r_wrb_pend ? r_wr_data  : '0;
`else
  assign ram_en_b_o   = 1'b0;
  assign ram_we_b_o   = 1'b0;
  assign ram_addr_b_o = '0;
  assign ram_din_b_o  = '0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = w_last_in ? FLUSH : LOAD;
      LOAD:    if (w_accept && w_last_in) w_state_nxt = FLUSH;
      FLUSH:   w_state_nxt = CALC;
      CALC:    if (calc_done_i) w_state_nxt = UNLOAD;
      UNLOAD:  if (w_pop && w_last_out) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Start pulse marker: set only for the cycle right after FLUSH
  always_ff @(posedge clk) begin
    if (rst) r_calc_first <= 1'b0;
    else     r_calc_first <= (r_state == FLUSH);
  end

  // Load path: register each accepted beat into a one-cycle-later RAM write
  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_cnt   <= '0;
      r_row      <= '0;
      r_col      <= '0;
      r_wr_pend  <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
`ifdef JACOBI_SYM_LOAD_EN
      r_wrb_pend <= 1'b0;
      r_wrb_addr <= '0;
`endif
    end else begin
      r_wr_pend  <= w_accept;
`ifdef JACOBI_SYM_LOAD_EN
      r_wrb_pend <= w_accept && (r_row != r_col);
`endif
      if (w_accept) begin
        r_wr_addr  <= elem_addr(r_row, r_col);
        r_wr_data  <= in_dat_i;
`ifdef JACOBI_SYM_LOAD_EN
        r_wrb_addr <= elem_addr(r_col, r_row);
`endif
        if (w_last_in) begin
          r_in_cnt <= '0;
          r_row    <= '0;
          r_col    <= '0;
        end else begin
          r_in_cnt <= r_in_cnt + CNT_W'(1);
          if (r_col == IDX_W'(N - 1)) begin
            r_row <= r_row + IDX_W'(1);
`ifdef JACOBI_SYM_LOAD_EN
            // Next row of the upper triangle starts on its diagonal
            r_col <= r_row + IDX_W'(1);
`else
            r_col <= '0;
`endif
          end else begin
            r_col <= r_col + IDX_W'(1);
          end
        end
      end
    end
  end

  // Unload path: issue reads, capture 1-cycle-latency data, drain to output
  always_ff @(posedge clk) begin
    if (rst || r_state != UNLOAD) begin
      r_rd_cnt   <= '0;
      r_out_cnt  <= '0;
      r_rd_pend  <= 1'b0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_fifo_cnt <= '0;
    end else begin
      r_rd_pend <= w_rd_issue;
      if (w_rd_issue) r_rd_cnt <= r_rd_cnt + CNT_W'(1);
      if (r_rd_pend) begin
        r_mem[r_wptr] <= ram_dout_a_i;
        r_wptr        <= r_wptr + 2'd1;
      end
      if (w_pop) begin
        r_rptr    <= r_rptr + 2'd1;
        r_out_cnt <= r_out_cnt + CNT_W'(1);
      end
      r_fifo_cnt <= r_fifo_cnt + {2'b00, r_rd_pend} - {2'b00, w_pop};
    end
  end

endmodule

// File: tb/tb_jacobi_matrix_io_controller.sv
// Directed testbench for jacobi_matrix_io_controller (N=4, DATA_W=16).
// Build with +define+JACOBI_SYM_LOAD_EN to exercise the symmetric-load mode.
module tb_jacobi_matrix_io_controller;
  localparam int DATA_W = 16;
  localparam int N      = 4;
  localparam int ADDR_W = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [DATA_W-1:0] in_dat_i = '0;
  logic              in_vld_i = 1'b0;
  logic              in_rdy_o;
  logic [DATA_W-1:0] out_dat_o;
  logic              out_vld_o;
  logic              out_rdy_i = 1'b1;
  logic              calc_start_o;
  logic              calc_done_i = 1'b0;
  logic              ram_en_a_o, ram_we_a_o, ram_en_b_o, ram_we_b_o;
  logic [ADDR_W-1:0] ram_addr_a_o, ram_addr_b_o;
  logic [DATA_W-1:0] ram_din_a_o, ram_din_b_o;
  logic [DATA_W-1:0] ram_dout_a_i = '0;
  logic [2:0]        dbg_state_o;

  jacobi_matrix_io_controller #(.DATA_W(DATA_W), .N(N), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .in_dat_i(in_dat_i), .in_vld_i(in_vld_i), .in_rdy_o(in_rdy_o),
    .out_dat_o(out_dat_o), .out_vld_o(out_vld_o), .out_rdy_i(out_rdy_i),
    .calc_start_o(calc_start_o), .calc_done_i(calc_done_i),
    .ram_en_a_o(ram_en_a_o), .ram_we_a_o(ram_we_a_o),
    .ram_addr_a_o(ram_addr_a_o), .ram_din_a_o(ram_din_a_o),
    .ram_dout_a_i(ram_dout_a_i),
    .ram_en_b_o(ram_en_b_o), .ram_we_b_o(ram_we_b_o),
    .ram_addr_b_o(ram_addr_b_o), .ram_din_b_o(ram_din_b_o),
    .dbg_state_o(dbg_state_o)
  );

  localparam logic [2:0] ST_IDLE = 3'd0, ST_FLUSH = 3'd2, ST_CALC = 3'd3, ST_UNLOAD = 3'd4;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rdy_mode = 0;
  int pat_idx = 0;

  // ---------------- dual-port RAM model ----------------
  logic [DATA_W-1:0] ram_mem [0:15];
  always @(posedge clk) begin
    if (ram_en_a_o && ram_we_a_o) ram_mem[ram_addr_a_o] <= ram_din_a_o;
    if (ram_en_a_o && !ram_we_a_o) ram_dout_a_i <= ram_mem[ram_addr_a_o];
    if (ram_en_b_o && ram_we_b_o) ram_mem[ram_addr_b_o] <= ram_din_b_o;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // out_rdy_i pattern: mode 0 always ready, mode 1 repeats 1,0,0,1
  always @(posedge clk) begin
    #1;
    if (rdy_mode == 0) out_rdy_i = 1'b1;
    else               out_rdy_i = (pat_idx % 4 == 0) || (pat_idx % 4 == 3);
    pat_idx = pat_idx + 1;
  end

  // ---------------- monitor / scoreboard capture ----------------
  int acc_cyc_q[$];
  int a_addr_q[$], a_cyc_q[$], b_addr_q[$], b_cyc_q[$];
  logic [DATA_W-1:0] a_data_q[$], b_data_q[$], out_q[$];
  logic [DATA_W-1:0] exp_q[$];
  int start_cnt = 0, calc_en_cnt = 0, stall_err = 0;
  int unload_cyc = 0, first_vld_cyc = 0, first_pop_cyc = 0, last_pop_cyc = 0;
  bit seen_vld = 0, seen_pop = 0;
  logic prev_vld = 0, prev_rdy = 0;
  logic [DATA_W-1:0] prev_dat = '0;
  logic [2:0] prev_state = 3'd0;

  always @(negedge clk) begin
    if (in_vld_i && in_rdy_o) acc_cyc_q.push_back(cyc);
    if (ram_en_a_o && ram_we_a_o) begin
      a_addr_q.push_back(int'(ram_addr_a_o));
      a_data_q.push_back(ram_din_a_o);
      a_cyc_q.push_back(cyc);
    end
    if (ram_en_b_o || ram_we_b_o) begin
      b_addr_q.push_back(int'(ram_addr_b_o));
      b_data_q.push_back(ram_din_b_o);
      b_cyc_q.push_back(cyc);
    end
    if (calc_start_o) start_cnt++;
    if (dbg_state_o == ST_CALC && (ram_en_a_o || ram_en_b_o)) calc_en_cnt++;
    if (dbg_state_o == ST_UNLOAD && prev_state != ST_UNLOAD) begin
      unload_cyc = cyc;
      seen_vld = 0;
      seen_pop = 0;
    end
    if (out_vld_o && !seen_vld) begin
      first_vld_cyc = cyc;
      seen_vld = 1;
    end
    if (!rst && prev_vld && !prev_rdy)
      if (!(out_vld_o && out_dat_o == prev_dat)) stall_err++;
    if (out_vld_o && out_rdy_i) begin
      out_q.push_back(out_dat_o);
      if (!seen_pop) first_pop_cyc = cyc;
      seen_pop = 1;
      last_pop_cyc = cyc;
    end
    prev_vld = out_vld_o;
    prev_rdy = out_rdy_i;
    prev_dat = out_dat_o;
    prev_state = dbg_state_o;
  end

  // ---------------- driver tasks ----------------
  // Sends n beats base, base+1, ...; pulses calc_done_i alongside beat done_at.
  task automatic send_beats(input int n, input logic [DATA_W-1:0] base, input int done_at);
    for (int i = 0; i < n; i++) begin
      int k;
      in_vld_i = 1'b1;
      in_dat_i = base + DATA_W'(i);
      calc_done_i = (i == done_at);
      k = 0;
      @(negedge clk);
      while (!in_rdy_o && k < 50) begin
        @(negedge clk);
        k++;
      end
      if (!in_rdy_o) begin
        errors++;
        checks++;
        $display("FAIL load_timeout: beat %0d in_rdy_o=%b, required 1", i, in_rdy_o);
      end
      @(posedge clk);
      #1;
      calc_done_i = 1'b0;
    end
    in_vld_i = 1'b0;
  endtask

  // Waits (bounded) for calc_start_o; leaves the caller at that negedge.
  task automatic wait_start();
    int k = 0;
    while (!calc_start_o && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!calc_start_o) begin
      errors++;
      checks++;
      $display("FAIL start_timeout: calc_start_o=%b, required 1", calc_start_o);
    end
  endtask

  task automatic pulse_done(input int delay);
    repeat (delay) @(posedge clk);
    #1 calc_done_i = 1'b1;
    @(posedge clk);
    #1 calc_done_i = 1'b0;
  endtask

  task automatic wait_idle(input int target);
    int k = 0;
    while (!(out_q.size() >= target && dbg_state_o == ST_IDLE) && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (k >= 400) begin
      errors++;
      checks++;
      $display("FAIL unload_timeout: outputs=%0d state=%0d, required %0d and 0",
               out_q.size(), dbg_state_o, target);
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- test tasks ----------------
  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (in_rdy_o !== 1'b0) begin errors++; $display("FAIL rst_in_rdy: got %b, required 0", in_rdy_o); end
    checks++;
    if ({out_vld_o, calc_start_o, ram_en_a_o, ram_we_a_o, ram_en_b_o, ram_we_b_o} !== 6'b0) begin
      errors++;
      $display("FAIL rst_ctrl: vld/start/ena/wea/enb/web=%b, required 000000",
               {out_vld_o, calc_start_o, ram_en_a_o, ram_we_a_o, ram_en_b_o, ram_we_b_o});
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (dbg_state_o !== ST_IDLE) begin errors++; $display("FAIL rst_state: got %0d, required 0", dbg_state_o); end
    checks++;
    if (in_rdy_o !== 1'b1) begin errors++; $display("FAIL idle_in_rdy: got %b, required 1", in_rdy_o); end
    checks++;
    if ({ram_addr_a_o, ram_din_a_o, ram_addr_b_o, ram_din_b_o} !== '0) begin
      errors++;
      $display("FAIL rst_addr_din: addrA=%0h dinA=%0h addrB=%0h dinB=%0h, required 0",
               ram_addr_a_o, ram_din_a_o, ram_addr_b_o, ram_din_b_o);
    end
    @(posedge clk);
    #1;
  endtask

`ifndef JACOBI_SYM_LOAD_EN
  task automatic test_full_load();
    int a0 = a_addr_q.size();
    int c0 = acc_cyc_q.size();
    int o0 = out_q.size();
    int s0 = start_cnt;
    int e0 = calc_en_cnt;
    send_beats(16, 16'h0001, -1);
    @(negedge clk);
    checks++;
    if (dbg_state_o !== ST_FLUSH || in_rdy_o !== 1'b0) begin
      errors++;
      $display("FAIL flush: state=%0d in_rdy=%b, required 2 and 0", dbg_state_o, in_rdy_o);
    end
    checks++;
    if ({ram_en_a_o, ram_we_a_o} !== 2'b11 || ram_addr_a_o !== 4'd15 || ram_din_a_o !== 16'h0010) begin
      errors++;
      $display("FAIL flush_write: en/we=%b addr=%0d din=%h, required 11 15 0010",
               {ram_en_a_o, ram_we_a_o}, ram_addr_a_o, ram_din_a_o);
    end
    wait_start();
    pulse_done(5);
    wait_idle(o0 + 16);
    checks++;
    if (a_addr_q.size() - a0 !== 16) begin
      errors++;
      $display("FAIL full_wr_count: got %0d, required 16", a_addr_q.size() - a0);
    end
    for (int i = 0; i < 16 && a0 + i < a_addr_q.size(); i++) begin
      checks++;
      if (a_addr_q[a0+i] !== i || a_data_q[a0+i] !== DATA_W'(i + 1)) begin
        errors++;
        $display("FAIL full_wr[%0d]: addr=%0d data=%h, required %0d %h",
                 i, a_addr_q[a0+i], a_data_q[a0+i], i, DATA_W'(i + 1));
      end
      checks++;
      if (a_cyc_q[a0+i] !== acc_cyc_q[c0+i] + 1) begin
        errors++;
        $display("FAIL full_wr_lat[%0d]: write cycle %0d, required %0d",
                 i, a_cyc_q[a0+i], acc_cyc_q[c0+i] + 1);
      end
    end
    checks++;
    if (start_cnt - s0 !== 1) begin errors++; $display("FAIL start_pulses: got %0d, required 1", start_cnt - s0); end
    checks++;
    if (calc_en_cnt !== e0) begin errors++; $display("FAIL calc_ram_en: got %0d cycles, required 0", calc_en_cnt - e0); end
    checks++;
    if (first_vld_cyc - unload_cyc > 3) begin
      errors++;
      $display("FAIL vld_latency: got %0d cycles, required <=3", first_vld_cyc - unload_cyc);
    end
    checks++;
    if (last_pop_cyc - first_pop_cyc !== 15) begin
      errors++;
      $display("FAIL throughput: 16 beats spanned %0d cycles, required 15", last_pop_cyc - first_pop_cyc);
    end
    for (int i = 0; i < 16; i++) exp_q.push_back(DATA_W'(i + 1));
    for (int i = 0; i < 16; i++) begin
      logic [DATA_W-1:0] e = exp_q.pop_front();
      checks++;
      if (o0 + i >= out_q.size() || out_q[o0+i] !== e) begin
        errors++;
        $display("FAIL full_out[%0d]: got %h, required %h", i,
                 (o0 + i < out_q.size()) ? out_q[o0+i] : 'x, e);
      end
    end
    checks++;
    if (out_q.size() - o0 !== 16) begin errors++; $display("FAIL full_out_count: got %0d, required 16", out_q.size() - o0); end
  endtask

  task automatic test_stall_unload();
    int o0 = out_q.size();
    int st0 = stall_err;
    send_beats(16, 16'h0100, -1);
    rdy_mode = 1;
    @(negedge clk);
    wait_start();
    // done coincident with the start pulse must be honoured
    calc_done_i = 1'b1;
    @(posedge clk);
    #1 calc_done_i = 1'b0;
    @(negedge clk);
    checks++;
    if (dbg_state_o !== ST_UNLOAD) begin errors++; $display("FAIL done_at_start: state=%0d, required 4", dbg_state_o); end
    wait_idle(o0 + 16);
    rdy_mode = 0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (out_q.size() - o0 !== 16) begin errors++; $display("FAIL stall_count: got %0d, required 16", out_q.size() - o0); end
    checks++;
    if (stall_err !== st0) begin errors++; $display("FAIL stall_hold: %0d unstable stall cycles, required 0", stall_err - st0); end
    for (int i = 0; i < 16; i++) exp_q.push_back(16'h0100 + DATA_W'(i));
    for (int i = 0; i < 16; i++) begin
      logic [DATA_W-1:0] e = exp_q.pop_front();
      checks++;
      if (o0 + i >= out_q.size() || out_q[o0+i] !== e) begin
        errors++;
        $display("FAIL stall_out[%0d]: got %h, required %h", i,
                 (o0 + i < out_q.size()) ? out_q[o0+i] : 'x, e);
      end
    end
  endtask

  task automatic test_reset_mid_load();
    int a0 = a_addr_q.size();
    int a1, o0;
    send_beats(7, 16'hAA00, -1);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (ram_en_a_o !== 1'b0 || in_rdy_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_abort: en_a=%b in_rdy=%b, required 0 0", ram_en_a_o, in_rdy_o);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (a_addr_q.size() - a0 !== 6) begin
      errors++;
      $display("FAIL rst_pending_wr: %0d writes, required 6", a_addr_q.size() - a0);
    end
    checks++;
    if (dbg_state_o !== ST_IDLE) begin errors++; $display("FAIL rst_mid_state: got %0d, required 0", dbg_state_o); end
    @(posedge clk);
    #1;
    a1 = a_addr_q.size();
    o0 = out_q.size();
    send_beats(16, 16'h0200, -1);
    @(negedge clk);
    wait_start();
    pulse_done(2);
    wait_idle(o0 + 16);
    for (int i = 0; i < 16 && a1 + i < a_addr_q.size(); i++) begin
      checks++;
      if (a_addr_q[a1+i] !== i || a_data_q[a1+i] !== 16'h0200 + DATA_W'(i)) begin
        errors++;
        $display("FAIL reload_wr[%0d]: addr=%0d data=%h, required %0d %h",
                 i, a_addr_q[a1+i], a_data_q[a1+i], i, 16'h0200 + DATA_W'(i));
      end
    end
    for (int i = 0; i < 16; i++) exp_q.push_back(16'h0200 + DATA_W'(i));
    for (int i = 0; i < 16; i++) begin
      logic [DATA_W-1:0] e = exp_q.pop_front();
      checks++;
      if (o0 + i >= out_q.size() || out_q[o0+i] !== e) begin
        errors++;
        $display("FAIL reload_out[%0d]: got %h, required %h", i,
                 (o0 + i < out_q.size()) ? out_q[o0+i] : 'x, e);
      end
    end
  endtask

  task automatic test_done_ignored();
    int o0 = out_q.size();
    send_beats(16, 16'h0300, 5);
    @(negedge clk);
    wait_start();
    repeat (10) @(negedge clk);
    checks++;
    if (dbg_state_o !== ST_CALC) begin errors++; $display("FAIL done_in_load: state=%0d, required 3", dbg_state_o); end
    checks++;
    if (out_vld_o !== 1'b0) begin errors++; $display("FAIL calc_no_out: out_vld=%b, required 0", out_vld_o); end
    pulse_done(1);
    wait_idle(o0 + 16);
    checks++;
    if (out_q.size() - o0 !== 16 || out_q[o0] !== 16'h0300 || out_q[o0+15] !== 16'h030F) begin
      errors++;
      $display("FAIL late_done_out: count=%0d first=%h last=%h, required 16 0300 030f",
               out_q.size() - o0, out_q[o0], out_q[out_q.size()-1]);
    end
    checks++;
    if (b_addr_q.size() !== 0) begin errors++; $display("FAIL portb_idle: %0d port B writes, required 0", b_addr_q.size()); end
  endtask
`else
  task automatic test_sym_load();
    int exp_a [10] = '{0, 1, 2, 3, 5, 6, 7, 10, 11, 15};
    int exp_b [6]  = '{4, 8, 12, 9, 13, 14};
    int src_b [6]  = '{1, 2, 3, 5, 6, 8};
    int mat [16]   = '{1, 2, 3, 4, 2, 5, 6, 7, 3, 6, 8, 9, 4, 7, 9, 10};
    int a0 = a_addr_q.size();
    int b0 = b_addr_q.size();
    int o0 = out_q.size();
    send_beats(10, 16'h0001, -1);
    @(negedge clk);
    wait_start();
    pulse_done(5);
    wait_idle(o0 + 16);
    checks++;
    if (a_addr_q.size() - a0 !== 10 || b_addr_q.size() - b0 !== 6) begin
      errors++;
      $display("FAIL sym_wr_count: A=%0d B=%0d, required 10 6", a_addr_q.size() - a0, b_addr_q.size() - b0);
    end
    for (int i = 0; i < 10 && a0 + i < a_addr_q.size(); i++) begin
      checks++;
      if (a_addr_q[a0+i] !== exp_a[i] || a_data_q[a0+i] !== DATA_W'(i + 1)) begin
        errors++;
        $display("FAIL sym_wr_a[%0d]: addr=%0d data=%h, required %0d %h",
                 i, a_addr_q[a0+i], a_data_q[a0+i], exp_a[i], DATA_W'(i + 1));
      end
    end
    for (int i = 0; i < 6 && b0 + i < b_addr_q.size(); i++) begin
      checks++;
      if (b_addr_q[b0+i] !== exp_b[i] || b_data_q[b0+i] !== DATA_W'(src_b[i] + 1) ||
          b_cyc_q[b0+i] !== a_cyc_q[a0+src_b[i]]) begin
        errors++;
        $display("FAIL sym_wr_b[%0d]: addr=%0d data=%h cyc=%0d, required %0d %h %0d",
                 i, b_addr_q[b0+i], b_data_q[b0+i], b_cyc_q[b0+i],
                 exp_b[i], DATA_W'(src_b[i] + 1), a_cyc_q[a0+src_b[i]]);
      end
    end
    for (int i = 0; i < 16; i++) exp_q.push_back(DATA_W'(mat[i]));
    for (int i = 0; i < 16; i++) begin
      logic [DATA_W-1:0] e = exp_q.pop_front();
      checks++;
      if (o0 + i >= out_q.size() || out_q[o0+i] !== e) begin
        errors++;
        $display("FAIL sym_out[%0d]: got %h, required %h", i,
                 (o0 + i < out_q.size()) ? out_q[o0+i] : 'x, e);
      end
    end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
`ifndef JACOBI_SYM_LOAD_EN
    test_full_load();
    test_stall_unload();
    test_reset_mid_load();
    test_done_ignored();
`else
    test_sym_load();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/jacobi_matrix_io_controller.md
JACOBI_MATRIX_IO_CONTROLLER -- requirements
Module: jacobi_matrix_io_controller

Interface
REQ-001 SHALL have parameter DATA_W, default 16, matrix element width in bits.
REQ-002 SHALL have parameter N, default 4, matrix dimension (N x N); legal range 2..16.
REQ-003 SHALL have parameter ADDR_W, default 4, RAM address width; SHALL satisfy 2^ADDR_W >= N*N.
REQ-004 SHALL have port clk, input, 1, clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port in_dat_i, input, DATA_W, matrix element from microcontroller.
REQ-007 SHALL have port in_vld_i, input, 1, input beat valid.
REQ-008 SHALL have port in_rdy_o, output, 1, input beat ready.
REQ-009 SHALL have port out_dat_o, output, DATA_W, result element to microcontroller.
REQ-010 SHALL have port out_vld_o, output, 1, output beat valid.
REQ-011 SHALL have port out_rdy_i, input, 1, output beat ready.
REQ-012 SHALL have port calc_start_o, output, 1, one-cycle start pulse to Jacobi engine.
REQ-013 SHALL have port calc_done_i, input, 1, engine finished pulse.
REQ-014 SHALL have ports ram_en_a_o, ram_we_a_o, output, 1 each, RAM port A enable/write-enable.
REQ-015 SHALL have port ram_addr_a_o, output, ADDR_W, RAM port A address.
REQ-016 SHALL have port ram_din_a_o, output, DATA_W, RAM port A write data.
REQ-017 SHALL have port ram_dout_a_i, input, DATA_W, RAM port A read data, 1-cycle read latency.
REQ-018 SHALL have ports ram_en_b_o, ram_we_b_o, output, 1 each, RAM port B enable/write-enable.
REQ-019 SHALL have port ram_addr_b_o, output, ADDR_W, RAM port B address.
REQ-020 SHALL have port ram_din_b_o, output, DATA_W, RAM port B write data.

Function
REQ-021 SHALL implement FSM states IDLE, LOAD, FLUSH, CALC, UNLOAD.
REQ-022 Beat accepted when in_vld_i && in_rdy_o; in_rdy_o SHALL be 1 only in IDLE and LOAD.
REQ-023 IDLE->LOAD on first accepted beat; LOAD->FLUSH on accepted last beat (count = NLOAD-1); FLUSH->CALC after 1 cycle; CALC->UNLOAD on calc_done_i; UNLOAD->IDLE after N*N-th output beat accepted.
REQ-024 Element (r,c) SHALL map to address r*N+c; load order row-major.
REQ-025 Beat accepted in cycle t SHALL produce port A write (en=we=1) in cycle t+1; en/we 0 otherwise during IDLE/LOAD/FLUSH.
REQ-026 Input counter SHALL wrap to 0 after last beat; when input count complete and in FLUSH, no further beat accepted.
REQ-027 calc_start_o SHALL pulse exactly one cycle, the first cycle of CALC; all RAM enables 0 throughout CALC.
REQ-028 calc_done_i outside CALC SHALL be ignored; calc_done_i coincident with calc_start_o SHALL be honoured.
REQ-029 UNLOAD SHALL read port A addresses 0..N*N-1 in order, buffering reads (>=2 entries) so no element is lost or duplicated under any out_rdy_i pattern.
REQ-030 out_vld_o SHALL first assert within 3 cycles of entering UNLOAD; with out_rdy_i held 1, SHALL sustain one beat per cycle.
REQ-031 out_dat_o SHALL hold stable while out_vld_o=1 and out_rdy_i=0.

Reset
REQ-032 On rst: state IDLE, counters 0, buffer emptied, in_rdy_o=0 during reset cycle, out_vld_o=0, calc_start_o=0, all RAM en/we 0, addr/din 0.
REQ-033 rst mid-LOAD/CALC/UNLOAD SHALL abort immediately; pending RAM write and buffered outputs discarded.

Configuration
REQ-034 With JACOBI_SYM_LOAD_EN defined: NLOAD=N*(N+1)/2, beats are upper triangle (c>=r) row-major; each write of (r,c) on port A SHALL, same cycle, write (c,r) on port B with same data, port B disabled when r==c.
REQ-035 Without JACOBI_SYM_LOAD_EN: NLOAD=N*N, port B en/we/addr/din held 0 always.

Verification
REQ-036 N=4, full mode: 16 beats 0x0001..0x0010 back-to-back, calc_done_i 5 cycles after start -> port A writes addr 0..15 in order, one calc_start_o pulse, 16 outputs 0x0001..0x0010.
REQ-037 UNLOAD with out_rdy_i toggling 1,0,0,1 repeating -> exactly 16 outputs, in order, data stable while stalled.
REQ-038 JACOBI_SYM_LOAD_EN, N=4: 10 beats 1..10 -> beat 2 writes A addr 1 and B addr 4 value 2; beat 5 writes A addr 5 only; readback yields symmetric matrix.
REQ-039 rst asserted after 7 load beats, then fresh 16-beat load -> new data lands at addr 0..15, old data never output.
REQ-040 calc_done_i pulsed during LOAD -> ignored; FSM still waits in CALC for later calc_done_i.
